apb_master_bridge: RTL

- Converts a simple valid/ready command/response interface into APB3 master transfers.
- Drives the psel/penable/paddr/pwdata/pwrite bus consumed by APB slaves, including the slave-side VIP interface, and returns prdata/pslverr to the requester.
- One outstanding transfer at a time; aborts a transfer if the slave never asserts pready.

---
 rtl/apb_master_bridge.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// Valid/ready command-to-APB3 master bridge: one outstanding transfer, with an
// optional ACCESS-phase timeout when the slave never raises pready.
module apb_master_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // A zero timeout still needs a 1-bit counter; it then saturates instead of aborting.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pwrite      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_write ? cmd_wdata : '0;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= S_SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= S_RESP;
          end else begin
            // Counter stops at TIMEOUT_CYCLES on abort, or at all-ones when disabled.
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_valid   <= 1'b1;
              psel        <= 1'b0;
              penable     <= 1'b0;
              state       <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
